aes_block_sequencer: RTL and testbench
======================================

Name: aes_block_sequencer

Overview:
- Sits directly downstream of the 128-bit block assembler that packs four 32-bit bus words into one AES block; consumes each assembled block and feeds the AES core.
- Queues incoming blocks in a small FIFO and issues them one at a time to the core with a start/busy/done handshake.
- Captures each 128-bit result and exposes it as four 32-bit words for bus readback, along with a completion counter and an overflow flag.

Parameters:
- DEPTH, 4, FIFO depth in blocks; must be a power of two and at least 2.
- CNT_W, 8, width of the completed-block counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  128  assembled block; word 0 sits in bits [127:96].
- in_valid  in  1  single-cycle strobe marking a new block on in_data.
- in_full  out  1  FIFO full, registered.
- aes_data  out  128  block presented to the core; stable from aes_start until the next aes_start.
- aes_start  out  1  one-cycle pulse that launches the core.
- aes_busy  in  1  core busy; no start may be issued while high.
- aes_done  in  1  one-cycle pulse; aes_result is valid in that cycle.
- aes_result  in  128  core output.
- rd_addr  in  2  selects a result word: 0 = [127:96], 1 = [95:64], 2 = [63:32], 3 = [31:0].
- rd_data  out  32  selected result word; combinational from the result register.
- result_valid  out  1  result register holds a completed block.
- blk_count  out  CNT_W  number of completed blocks; wraps modulo 2^CNT_W.
- overflow  out  1  sticky; set when a block is dropped.

Behaviour:
- Reset (asynchronous, active-low): FIFO empty, pointers 0, FSM in IDLE. aes_data, aes_start, the result register, result_valid, blk_count and overflow are all 0, and in_full is 0. Reset asserted mid-operation discards queued and in-flight blocks. A late aes_done that arrives after reset releases is ignored because the FSM is in IDLE.
- FIFO write: an in_valid edge with the FIFO not full stores in_data at the write pointer. The pointer wraps at DEPTH.
- Simultaneous push and pop while full: the push is accepted and the occupancy is unchanged.
- Push while full with no pop: the block is dropped, overflow is set to 1 and stays set until reset, and FIFO contents are unchanged.
- in_full = (occupancy == DEPTH), registered.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if the FIFO is not empty and aes_busy == 0, load aes_data with the FIFO head, pop, drive aes_start = 1 for the next cycle, clear result_valid, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive aes_start = 0 and go to WAIT. aes_done in this state is ignored.
  - WAIT: on aes_done, capture aes_result into the result register, set result_valid = 1, increment blk_count (wrapping), and go to IDLE. Otherwise stay in WAIT.
  - aes_done in IDLE is ignored.
- Latency, with the FIFO empty, the FSM in IDLE and aes_busy low:
  - in_valid sampled at edge E writes the block.
  - The FSM sees it at edge E+1.
  - aes_start is high for exactly the cycle between edges E+1 and E+2.
- Back-to-back issue: the next aes_start comes no earlier than one cycle after the edge that sampled aes_done, and only while aes_busy is low.
- Only one block is in flight at a time. FIFO order is preserved: the result sequence matches the input order.
- rd_data follows rd_addr in the same cycle. It reads the last captured result, or 0 after reset.

Test Plan:
- Single block: reset, then one in_valid with in_data = 0x00112233_44556677_8899AABB_CCDDEEFF, aes_busy = 0. Required: one-cycle aes_start exactly 2 edges after the strobe, aes_data equal to that value. Then aes_done with aes_result = 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A. Required: result_valid = 1, blk_count = 1, rd_addr 0..3 returning 69C4E0D8, 6A7B0430, D8CDB780, 70B4C55A.
- Ordering: 4 strobes with in_data = 1, 2, 3, 4 on consecutive cycles. Required: aes_start issued 4 times, with aes_data = 1, 2, 3, 4 in order, each waiting for aes_done; blk_count = 4 at the end.
- Overflow: hold aes_busy = 1 and strobe 5 blocks. Required: in_full = 1 after the 4th, 5th block dropped, overflow = 1. Then release busy. Required: exactly 4 blocks issued, overflow still 1.
- Full plus pop: with the FIFO full, strobe in_valid in the same cycle the FSM pops. Required: block accepted, overflow stays 0, in_full stays 1.
- Reset mid-flight: assert reset in WAIT with 2 blocks queued. Required: all outputs 0 immediately. A subsequent aes_done pulse must leave result_valid = 0 and blk_count = 0.
- Counter wrap: with CNT_W = 2, run 5 blocks. Required: blk_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/aes_block_sequencer.sv
// Queues assembled 128-bit blocks, issues them one at a time to the AES core
// and holds the latest result for 32-bit bus readback.
module aes_block_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [127:0]     in_data,
  input  logic             in_valid,
  output logic             in_full,
  output logic [127:0]     aes_data,
  output logic             aes_start,
  input  logic             aes_busy,
  input  logic             aes_done,
  input  logic [127:0]     aes_result,
  input  logic [1:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             result_valid,
  output logic [CNT_W-1:0] blk_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state, state_next;
  logic [127:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_next;
  logic [127:0]   result;
  logic           fifo_full, fifo_empty;
  logic           push, pop, drop, capture;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !aes_busy) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (aes_done) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push = in_valid && (!fifo_full || pop);
  assign drop = in_valid && fifo_full && !pop;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_full  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      in_full <= (count_next == FULL_CNT);
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aes_data     <= '0;
      aes_start    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      blk_count    <= '0;
    end else begin
      aes_start <= pop;
      if (pop) begin
        aes_data     <= mem[rd_ptr];
        result_valid <= 1'b0;
      end
      if (capture) begin
        result       <= aes_result;
        result_valid <= 1'b1;
        blk_count    <= blk_count + 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = result[127:96];
    case (rd_addr)
      2'd0: rd_data = result[127:96];
      2'd1: rd_data = result[95:64];
      2'd2: rd_data = result[63:32];
      2'd3: rd_data = result[31:0];
      default: rd_data = result[127:96];
    endcase
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Self-checking bench: a queue-based model of the sequencer predicts every output
// each cycle, alongside directed scenarios with literal expectations.
module tb_aes_block_sequencer;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic [1:0]   rd_addr = '0;
  logic         busy_hold = 1'b0;
  logic         man_done = 1'b0;
  logic [127:0] man_result = '0;
  logic         core_auto = 1'b0;
  logic         core_busy = 1'b0;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
  logic [127:0] core_in = '0;
  int           core_cnt = 0;

  logic         aes_busy, aes_done;
  logic [127:0] aes_result;
  assign aes_busy   = busy_hold | core_busy;
  assign aes_done   = man_done | core_done;
  assign aes_result = man_done ? man_result : core_result;

  logic         in_full, aes_start, result_valid, overflow;
  logic [127:0] aes_data;
  logic [31:0]  rd_data;
  logic [7:0]   blk_count;
  logic         s_in_full, s_aes_start, s_result_valid, s_overflow;
  logic [127:0] s_aes_data;
  logic [31:0]  s_rd_data;
  logic [1:0]   s_blk_count;

  aes_block_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_full(in_full), .aes_data(aes_data), .aes_start(aes_start),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_result(aes_result),
    .rd_addr(rd_addr), .rd_data(rd_data), .result_valid(result_valid),
    .blk_count(blk_count), .overflow(overflow)
  );

  aes_block_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_full(s_in_full), .aes_data(s_aes_data), .aes_start(s_aes_start),
    .aes_busy(aes_busy), .aes_done(aes_done), .aes_result(aes_result),
    .rd_addr(rd_addr), .rd_data(s_rd_data), .result_valid(s_result_valid),
    .blk_count(s_blk_count), .overflow(s_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  // Behavioural model: a plain queue plus "one block in flight" bookkeeping.
  logic [127:0] m_q[$];
  bit           m_inflight = 0, m_armed = 0, m_can_pop, m_accept;
  logic         m_start = 0, m_full = 0, m_rv = 0, m_ovf = 0;
  logic [127:0] m_data = '0, m_result = '0;
  int           m_cnt = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_inflight = 0; m_armed = 0;
      m_start = 0; m_full = 0; m_rv = 0; m_ovf = 0;
      m_data = '0; m_result = '0; m_cnt = 0;
    end else begin
      m_can_pop = !m_inflight && (m_q.size() != 0) && !aes_busy;
      m_accept  = in_valid && ((m_q.size() < DEPTH) || m_can_pop);
      m_start   = 0;
      if (m_can_pop) begin
        m_data = m_q.pop_front();
        m_start = 1; m_rv = 0; m_inflight = 1; m_armed = 0;
      end else if (m_inflight && !m_armed) begin
        m_armed = 1;
      end else if (m_inflight && aes_done) begin
        m_result = aes_result; m_rv = 1; m_cnt++; m_inflight = 0;
      end
      if (m_accept) m_q.push_back(in_data);
      else if (in_valid) m_ovf = 1;
      m_full = (m_q.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    #1;
    checkOutput("cyc_aes_start", aes_start, m_start);
    checkOutput("cyc_aes_data", aes_data, m_data);
    checkOutput("cyc_in_full", in_full, m_full);
    checkOutput("cyc_result_valid", result_valid, m_rv);
    checkOutput("cyc_overflow", overflow, m_ovf);
    checkOutput("cyc_blk_count", blk_count, 128'(m_cnt % 256));
    checkOutput("cyc_blk_count_small", s_blk_count, 128'(m_cnt % 4));
    checkOutput("cyc_rd_data", rd_data, m_result[127 - 32*rd_addr -: 32]);
  end

  // Simple stand-in for the AES core with a random latency.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done   = 1'b1;
        core_busy   = 1'b0;
        core_result = {core_in[63:0], core_in[127:64]} ^ 128'hA5A5_0F0F_3C3C_9696_A5A5_0F0F_3C3C_9696;
      end
    end else if (core_auto && aes_start) begin
      core_in   = aes_data;
      core_cnt  = 1 + $urandom_range(0, 3);
      core_busy = 1'b1;
    end
  end

  logic [127:0] issued[$];
  logic [1:0]   cnt_log[$];
  logic [1:0]   prev_small = '0;

  always @(negedge clk) begin
    if (reset && aes_start) issued.push_back(aes_data);
    if (s_blk_count != prev_small) begin
      if (reset) cnt_log.push_back(s_blk_count);
      prev_small = s_blk_count;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; man_done = 1'b0; busy_hold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_count(input int target, input string name);
    int n = 0;
    while (blk_count != 8'(target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    #2;
    checkOutput(name, blk_count, 128'(target));
  endtask

  task automatic check_issued(input string name, input int n, input logic [127:0] first);
    checkOutput({name, "_n"}, 128'(issued.size()), 128'(n));
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_%0d", name, i),
                  (i < issued.size()) ? issued[i] : '1, first + 128'(i));
  endtask

  localparam logic [127:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] RES = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
  localparam logic [31:0]  RES_W [4] = '{32'h69C4E0D8, 32'h6A7B0430, 32'hD8CDB780, 32'h70B4C55A};

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_aes_start", aes_start, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_blk_count", blk_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single block, start two edges after the strobe.
    applyStimulus(1'b1, BLK);
    applyStimulus(1'b0, '0);
    #2 checkOutput("single_start_e1", aes_start, 0);
    @(negedge clk);
    #2 checkOutput("single_start_e2", aes_start, 1);
    checkOutput("single_aes_data", aes_data, BLK);
    @(negedge clk);
    #2 checkOutput("single_start_low", aes_start, 0);
    @(negedge clk); man_done = 1'b1; man_result = RES;
    @(negedge clk); man_done = 1'b0;
    #2 checkOutput("single_rv", result_valid, 1);
    checkOutput("single_count", blk_count, 1);
    checkOutput("model_pin_result", m_result, RES);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rd_addr = 2'(i);
      #2 checkOutput($sformatf("single_rd_%0d", i), rd_data, RES_W[i]);
    end

    // Ordering.
    do_reset(); issued.delete(); core_auto = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 128'(i));
    applyStimulus(1'b0, '0);
    wait_count(4, "ord_count");
    check_issued("ord", 4, 128'd1);

    // Overflow with the core held busy.
    do_reset(); issued.delete(); busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 128'(10 + i));
    applyStimulus(1'b1, 128'd14);
    #2 checkOutput("ovf_full_after4", in_full, 1);
    checkOutput("ovf_not_yet", overflow, 0);
    applyStimulus(1'b0, '0);
    #2 checkOutput("ovf_set", overflow, 1);
    checkOutput("model_pin_ovf", m_ovf, 1);
    @(negedge clk); busy_hold = 1'b0;
    wait_count(4, "ovf_count");
    repeat (20) @(negedge clk);
    check_issued("ovf", 4, 128'd10);
    checkOutput("ovf_sticky", overflow, 1);

    // Full plus pop in the same cycle.
    do_reset(); issued.delete(); core_auto = 1'b0; busy_hold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 128'(20 + i));
    applyStimulus(1'b0, '0);
    @(negedge clk); busy_hold = 1'b0; in_valid = 1'b1; in_data = 128'd24;
    @(negedge clk); in_valid = 1'b0;
    #2 checkOutput("fp_start", aes_start, 1);
    checkOutput("fp_data", aes_data, 128'd20);
    checkOutput("fp_overflow", overflow, 0);
    checkOutput("fp_full", in_full, 1);
    @(negedge clk); man_done = 1'b1; man_result = 128'hBEEF;
    @(negedge clk); man_done = 1'b0; core_auto = 1'b1;
    wait_count(5, "fp_count");
    check_issued("fp", 5, 128'd20);
    checkOutput("fp_overflow_end", overflow, 0);

    // Reset while a block is in flight and two are queued.
    @(negedge clk); core_auto = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 128'(30 + i));
    applyStimulus(1'b0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2 checkOutput("mid_start", aes_start, 0);
    checkOutput("mid_data", aes_data, 0);
    checkOutput("mid_full", in_full, 0);
    checkOutput("mid_rv", result_valid, 0);
    checkOutput("mid_count", blk_count, 0);
    checkOutput("mid_ovf", overflow, 0);
    checkOutput("mid_rd", rd_data, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); man_done = 1'b1; man_result = 128'h1234;
    @(negedge clk); man_done = 1'b0;
    #2 checkOutput("late_done_rv", result_valid, 0);
    checkOutput("late_done_count", blk_count, 0);

    // Narrow counter wraps.
    do_reset(); core_auto = 1'b1;
    @(negedge clk); cnt_log.delete();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 128'(40 + i));
    applyStimulus(1'b0, '0);
    wait_count(5, "wrap_count");
    checkOutput("wrap_n", 128'(cnt_log.size()), 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("wrap_%0d", i), (i < cnt_log.size()) ? cnt_log[i] : 2'bx,
                  128'((i + 1) % 4));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 9) < 4);
      in_data    = {$urandom, $urandom, $urandom, $urandom};
      busy_hold  = ($urandom_range(0, 7) == 0);
      rd_addr    = 2'($urandom_range(0, 3));
      man_done   = ($urandom_range(0, 39) == 0);
      man_result = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk); in_valid = 1'b0; busy_hold = 1'b0; man_done = 1'b0;
    for (int n = 0; n < 300 && (m_q.size() != 0 || m_inflight || core_busy); n++)
      @(negedge clk);
    #2 checkOutput("rand_drain_count", blk_count, 128'(m_cnt % 256));
    checkOutput("rand_drain_empty", 128'(m_q.size()), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
